// File: rtl/op_share_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// op_share_arbiter_pkg
// Shared types for the operator-sharing arbiter: FSM state encoding, the
// operation selector encoding, and the EXEC countdown width.
// -----------------------------------------------------------------------------
package op_share_arbiter_pkg;

  // Arbiter FSM: wait for a request, run the shared operator, acknowledge.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Operation performed by the shared operator.
  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2
  } op_e;

  // OP_LATENCY tops out at 15, so the countdown never holds more than 14.
  localparam int CNT_W = 4;

endpackage

// File: rtl/op_share_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin search. Starting at last_grant+1 and wrapping
// modulo NUM_PORTS, returns the first requesting client.
//
// Ports:
//   req_i        - request vector, one bit per client
//   last_grant_i - index of the most recently served client
//   found_o      - at least one request bit is set
//   index_o      - winning client index (0 when found_o is low)
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]     last_grant_i,
  output logic                 found_o,
  output logic [IDX_W-1:0]     index_o
);

  logic [IDX_W-1:0] cand;

  // NOTE: every signal written in an always_comb gets a default before any
  // conditional logic; a path that leaves one unassigned infers a latch.
  always_comb begin
    found_o = 1'b0;
    index_o = '0;
    cand    = '0;
    // Walk offsets 1..NUM_PORTS so the last-served client is checked last.
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = IDX_W'((int'(last_grant_i) + k) % NUM_PORTS);
      if (!found_o && req_i[cand]) begin
        found_o = 1'b1;
        index_o = cand;
      end
    end
  end

endmodule

// File: rtl/op_share_arbiter.sv
// -----------------------------------------------------------------------------
// op_share_arbiter
// Shares one arithmetic operator (add, sub or mul) among NUM_PORTS clients.
// A round-robin pick grants one requester, its operands are latched, the
// operator runs for OP_LATENCY cycles, and the result is returned with a
// one-cycle acknowledge to the granted client.
//
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-low reset
//   cl_req   - per-client level request
//   cl_a     - operand A, client i at [i*DATA_WIDTH +: DATA_WIDTH]
//   cl_b     - operand B, same packing as cl_a
//   cl_ack   - one-cycle completion pulse to the granted client
//   cl_dout  - shared result, held until the next completion
//   busy     - high while an operation is executing or responding
//   grant_id - index of the current or last granted client
// -----------------------------------------------------------------------------
module op_share_arbiter
  import op_share_arbiter_pkg::*;
#(
  parameter int    DATA_WIDTH = 32,
  parameter int    NUM_PORTS  = 4,
  parameter int    OP_LATENCY = 2,
  parameter string OP         = "add"
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            cl_req,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] cl_a,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] cl_b,
  output logic [NUM_PORTS-1:0]            cl_ack,
  output logic [DATA_WIDTH-1:0]           cl_dout,
  output logic                            busy,
  output logic [$clog2(NUM_PORTS)-1:0]    grant_id
);

  localparam int  IDX_W    = $clog2(NUM_PORTS);
  localparam bit  OP_VALID = (OP == "add") || (OP == "sub") || (OP == "mul");
  localparam op_e OP_SEL   = (OP == "sub") ? OP_SUB :
                             (OP == "mul") ? OP_MUL : OP_ADD;

  // Bad configurations stop elaboration instead of building wrong hardware.
  if (!OP_VALID) begin : g_bad_op
    $error("op_share_arbiter: OP must be \"add\", \"sub\" or \"mul\"");
  end
  if (NUM_PORTS < 2 || NUM_PORTS > 8) begin : g_bad_ports
    $error("op_share_arbiter: NUM_PORTS must be in 2..8");
  end
  if (OP_LATENCY < 1 || OP_LATENCY > 15) begin : g_bad_latency
    $error("op_share_arbiter: OP_LATENCY must be in 1..15");
  end

  // Per-client operand views of the packed buses.
  logic [DATA_WIDTH-1:0] a_arr [NUM_PORTS];
  logic [DATA_WIDTH-1:0] b_arr [NUM_PORTS];

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
    assign a_arr[g] = cl_a[g*DATA_WIDTH +: DATA_WIDTH];
    assign b_arr[g] = cl_b[g*DATA_WIDTH +: DATA_WIDTH];
  end

  state_e                state_q,  state_d;
  logic [CNT_W-1:0]      cnt_q,    cnt_d;
  logic [DATA_WIDTH-1:0] a_q,      a_d;
  logic [DATA_WIDTH-1:0] b_q,      b_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [DATA_WIDTH-1:0] dout_q,   dout_d;
  logic [NUM_PORTS-1:0]  ack_q,    ack_d;
  logic [IDX_W-1:0]      grant_q,  grant_d;
  logic [IDX_W-1:0]      last_q,   last_d;

  logic                  pick_found;
  logic [IDX_W-1:0]      pick_idx;
  logic [DATA_WIDTH-1:0] op_res;

  rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_rr_pick (
    .req_i        (cl_req),
    .last_grant_i (last_q),
    .found_o      (pick_found),
    .index_o      (pick_idx)
  );

  // Shared operator on the latched operands only; results wrap at DATA_WIDTH.
  always_comb begin
    case (OP_SEL)
      OP_SUB:  op_res = a_q - b_q;
      OP_MUL:  op_res = a_q * b_q;
      default: op_res = a_q + b_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    dout_d   = dout_q;
    ack_d    = '0;
    grant_d  = grant_q;
    last_d   = last_q;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          a_d     = a_arr[pick_idx];
          b_d     = b_arr[pick_idx];
          cnt_d   = CNT_W'(OP_LATENCY - 1);
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          result_d = op_res;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        // The ack register goes high on the edge leaving RESP, so a reset on
        // that same edge suppresses it.
        ack_d[grant_q] = 1'b1;
        dout_d         = result_q;
        last_d         = grant_q;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      dout_q   <= '0;
      ack_q    <= '0;
      grant_q  <= '0;
      // Last grant at the top port makes port 0 the first winner.
      last_q   <= IDX_W'(NUM_PORTS - 1);
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      dout_q   <= dout_d;
      ack_q    <= ack_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
    end
  end

  assign cl_ack   = ack_q;
  assign cl_dout  = dout_q;
  assign busy     = (state_q != IDLE);
  assign grant_id = grant_q;

endmodule

// File: tb/tb_op_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_op_share_arbiter
// Directed bench for op_share_arbiter (4 ports, latency 2). One "add"
// instance carries most scenarios; a second "sub" instance covers wrap on
// subtraction. Expected completions (port, data, cycle) are queued when the
// request is driven and compared when an ack appears.
// -----------------------------------------------------------------------------
module tb_op_share_arbiter;

  localparam int W = 32;
  localparam int N = 4;

  typedef struct {
    int          port;
    logic [W-1:0] data;
    int          cyc;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b0;

  logic [N-1:0]   req_a,  ack_a;
  logic [N*W-1:0] a_a,    b_a;
  logic [W-1:0]   dout_a;
  logic           busy_a;
  logic [1:0]     gid_a;

  logic [N-1:0]   req_s,  ack_s;
  logic [N*W-1:0] a_s,    b_s;
  logic [W-1:0]   dout_s;
  logic           busy_s;
  logic [1:0]     gid_s;

  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   port_acks [N];
  exp_t q_a [$];
  exp_t q_s [$];
  logic [N-1:0] prev_a = '0;
  logic [N-1:0] prev_s = '0;

  always #5 clk = ~clk;

  op_share_arbiter #(
    .DATA_WIDTH (W),
    .NUM_PORTS  (N),
    .OP_LATENCY (2),
    .OP         ("add")
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .cl_req   (req_a),
    .cl_a     (a_a),
    .cl_b     (b_a),
    .cl_ack   (ack_a),
    .cl_dout  (dout_a),
    .busy     (busy_a),
    .grant_id (gid_a)
  );

  op_share_arbiter #(
    .DATA_WIDTH (W),
    .NUM_PORTS  (N),
    .OP_LATENCY (2),
    .OP         ("sub")
  ) u_dut_sub (
    .clk      (clk),
    .rst      (rst),
    .cl_req   (req_s),
    .cl_a     (a_s),
    .cl_b     (b_s),
    .cl_ack   (ack_s),
    .cl_dout  (dout_s),
    .busy     (busy_s),
    .grant_id (gid_s)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare any completion against the scoreboard heads.
  task automatic monitor();
    exp_t e;
    if (ack_a !== '0) begin
      if (q_a.size() == 0) begin
        check("add_unexpected_ack", 64'(ack_a), 64'(0));
      end else begin
        e = q_a.pop_front();
        check("add_ack_vec", 64'(ack_a), 64'(4'b0001 << e.port));
        check("add_dout",    64'(dout_a), 64'(e.data));
        check("add_grant_id", 64'(gid_a), 64'(e.port));
        check("add_ack_cycle", 64'(cyc), 64'(e.cyc));
        check("add_ack_gap", 64'(ack_a & prev_a), 64'(0));
        for (int i = 0; i < N; i++) if (ack_a[i]) port_acks[i]++;
      end
    end
    if (ack_s !== '0) begin
      if (q_s.size() == 0) begin
        check("sub_unexpected_ack", 64'(ack_s), 64'(0));
      end else begin
        e = q_s.pop_front();
        check("sub_ack_vec", 64'(ack_s), 64'(4'b0001 << e.port));
        check("sub_dout",    64'(dout_s), 64'(e.data));
        check("sub_ack_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    prev_a = ack_a;
    prev_s = ack_s;
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    monitor();
  endtask

  task automatic drain(input int budget);
    int left;
    left = budget;
    while ((q_a.size() != 0 || q_s.size() != 0) && left > 0) begin
      step();
      left--;
    end
    check("drain_pending", 64'(q_a.size() + q_s.size()), 64'(0));
  endtask

  initial begin
    for (int i = 0; i < N; i++) port_acks[i] = 0;
    req_a = '1;
    req_s = '1;
    a_a = {$urandom, $urandom, $urandom, $urandom};
    b_a = {$urandom, $urandom, $urandom, $urandom};
    a_s = '0;
    b_s = '0;

    // Reset held with requests pending: nothing may start.
    rst = 1'b0;
    repeat (3) step();
    check("rst_ack",   64'(ack_a),  64'(0));
    check("rst_dout",  64'(dout_a), 64'(0));
    check("rst_busy",  64'(busy_a), 64'(0));
    check("rst_gid",   64'(gid_a),  64'(0));
    check("rst_sub_busy", 64'(busy_s), 64'(0));
    req_s = '0;
    rst   = 1'b1;
    cyc   = 0;

    // All ports requesting: grants 0,1,2,3,... one op every 4 cycles.
    req_a = '1;
    for (int n = 0; n < 1000; n++) begin
      int           p;
      logic [W-1:0] x, y;
      p = n % N;
      x = $urandom;
      y = $urandom;
      a_a[p*W +: W] = x;
      b_a[p*W +: W] = y;
      q_a.push_back('{port: p, data: x + y, cyc: cyc + 4});
      step();
      a_a[p*W +: W] = ~x;
      if (n == 999) req_a = '0;
      repeat (3) step();
    end
    drain(8);
    for (int i = 0; i < N; i++) check($sformatf("rr_acks_port%0d", i), 64'(port_acks[i]), 64'(250));
    check("rr_idle_busy", 64'(busy_a), 64'(0));

    // Single request on port 2: 5 + 7.
    a_a[2*W +: W] = 32'd5;
    b_a[2*W +: W] = 32'd7;
    req_a = 4'b0100;
    q_a.push_back('{port: 2, data: 32'd12, cyc: cyc + 4});
    step();
    check("p2_busy", 64'(busy_a), 64'(1));
    check("p2_gid",  64'(gid_a),  64'(2));
    req_a = '0;
    drain(10);
    repeat (3) step();
    check("p2_dout_hold", 64'(dout_a), 64'(12));
    check("p2_ack_low",   64'(ack_a),  64'(0));
    check("p2_busy_low",  64'(busy_a), 64'(0));

    // Wrap-around: add overflow and sub underflow.
    a_a[0 +: W] = 32'hFFFF_FFFF;
    b_a[0 +: W] = 32'd2;
    req_a = 4'b0001;
    q_a.push_back('{port: 0, data: 32'd1, cyc: cyc + 4});
    a_s[0 +: W] = 32'd3;
    b_s[0 +: W] = 32'd5;
    req_s = 4'b0001;
    q_s.push_back('{port: 0, data: 32'hFFFF_FFFE, cyc: cyc + 4});
    step();
    req_a = '0;
    req_s = '0;
    drain(10);

    // Port 1: operand changed after grant, request dropped during EXEC.
    a_a[1*W +: W] = 32'd10;
    b_a[1*W +: W] = 32'd20;
    req_a = 4'b0010;
    q_a.push_back('{port: 1, data: 32'd30, cyc: cyc + 4});
    step();
    check("p1_gid", 64'(gid_a), 64'(1));
    a_a[1*W +: W] = 32'd99;
    step();
    req_a = '0;
    drain(10);
    repeat (6) step();
    check("p1_single_ack_busy", 64'(busy_a), 64'(0));

    // Reset during EXEC (d=1) and on the edge the ack is due (d=2).
    for (int d = 1; d <= 2; d++) begin
      a_a[3*W +: W] = 32'd1;
      b_a[3*W +: W] = 32'd1;
      req_a = 4'b1000;
      step();
      check($sformatf("abort%0d_gid", d), 64'(gid_a), 64'(3));
      req_a = '0;
      repeat (d) step();
      rst = 1'b0;
      step();
      check($sformatf("abort%0d_ack",  d), 64'(ack_a),  64'(0));
      check($sformatf("abort%0d_busy", d), 64'(busy_a), 64'(0));
      check($sformatf("abort%0d_gid0", d), 64'(gid_a),  64'(0));
      check($sformatf("abort%0d_dout", d), 64'(dout_a), 64'(0));
      rst = 1'b1;
      repeat (4) step();
    end

    // After reset, port 1 wins over port 3.
    a_a[1*W +: W] = 32'd11;
    b_a[1*W +: W] = 32'd22;
    req_a = 4'b1010;
    q_a.push_back('{port: 1, data: 32'd33, cyc: cyc + 4});
    step();
    check("post_rst_gid", 64'(gid_a), 64'(1));
    req_a = '0;
    drain(10);
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/op_share_arbiter.md
OP_SHARE_ARBITER -- requirements
Module: op_share_arbiter

Interface
REQ-001 The block SHALL have a parameter DATA_WIDTH, default 32, giving the operand and result width.
REQ-002 The block SHALL have a parameter NUM_PORTS, default 4, giving the number of client ports (range 2..8).
REQ-003 The block SHALL have a parameter OP_LATENCY, default 2, giving the EXEC cycles (range 1..15).
REQ-004 The block SHALL have a parameter OP, default "add", selecting the operation ("add", "sub" or "mul").
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic on rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-007 The block SHALL have port cl_req, input, NUM_PORTS bits: per-client level request; held high means a continuous stream of requests.
REQ-008 The block SHALL have port cl_a, input, NUM_PORTS*DATA_WIDTH bits: operand A, client i at slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 The block SHALL have port cl_b, input, NUM_PORTS*DATA_WIDTH bits: operand B, same packing as cl_a.
REQ-010 The block SHALL have port cl_ack, output, NUM_PORTS bits: one-cycle completion pulse for the granted client.
REQ-011 The block SHALL have port cl_dout, output, DATA_WIDTH bits: shared result, valid while cl_ack is high and held until the next completion.
REQ-012 The block SHALL have port busy, output, 1 bit: high in EXEC and RESP.
REQ-013 The block SHALL have port grant_id, output, clog2(NUM_PORTS) bits: index of the current or last granted client.

Function
REQ-014 The FSM SHALL have the states IDLE, EXEC and RESP.
REQ-015 In IDLE with any cl_req bit set, the block SHALL grant the first set bit searching from last_grant+1 modulo NUM_PORTS, latch that client's A and B, load cnt = OP_LATENCY-1, and go to EXEC.
REQ-016 In IDLE with no cl_req bit set, the block SHALL stay in IDLE.
REQ-017 In EXEC, cnt SHALL decrement each cycle; at cnt==0 the block SHALL register the result and go to RESP.
REQ-018 In RESP, the block SHALL drive cl_ack[grant]=1 for exactly one cycle and update cl_dout, then set last_grant=grant and return to IDLE.
REQ-019 Latency SHALL be: a grant taken at edge T produces cl_ack at edge T+OP_LATENCY+1.
REQ-020 Sustained throughput SHALL be one operation per OP_LATENCY+2 cycles.
REQ-021 At most one cl_ack bit SHALL be high in any cycle, and no port SHALL receive ack in consecutive cycles.
REQ-022 Results SHALL be taken modulo 2^DATA_WIDTH: add and sub wrap, and mul returns the low DATA_WIDTH bits.
REQ-023 Only latched operands SHALL be used; changes to cl_a or cl_b after the grant SHALL have no effect.
REQ-024 If cl_req drops during EXEC, the operation SHALL still complete and ack SHALL still be issued.
REQ-025 Round-robin SHALL bound the wait of any continuously requesting port to NUM_PORTS-1 other grants.
REQ-026 An unsupported OP value SHALL be rejected at elaboration.

Reset
REQ-027 While rst==0 at a clock edge, the block SHALL set: state IDLE, cl_ack 0, cl_dout 0, busy 0, grant_id 0, cnt 0, last_grant NUM_PORTS-1 (port 0 wins first).
REQ-028 Reset during EXEC or RESP SHALL abort the operation with no ack issued, including an ack that was due in the same cycle.

Structure
REQ-029 A shared package SHALL hold the state enum (IDLE/EXEC/RESP) and the OP encodings.
REQ-030 There SHALL be one combinational sub-module, rr_pick (inputs: request vector, last_grant; outputs: found, index), instantiated once.

Verification
REQ-031 Bench configuration SHALL be N=4, OP_LATENCY=2, OP="add"; rst is released at cycle 0.
REQ-032 Scenario: cl_req[2] only, A=5, B=7, sampled at T -> cl_ack[2] at T+3, cl_dout=12, grant_id=2.
REQ-033 Scenario: all four cl_req held high -> grant order 0,1,2,3,0,..., acks 4 cycles apart, 1000 ops with 250 per port.
REQ-034 Scenario: A=0xFFFFFFFF, B=2 with add -> 1; OP="sub", A=3, B=5 -> 0xFFFFFFFE.
REQ-035 Scenario: cl_req[1] dropped one cycle after grant -> exactly one cl_ack[1]; A changed to 99 after grant -> result uses the original A.
REQ-036 Scenario: rst=0 in EXEC of a port-3 op -> no cl_ack; after release with cl_req=4'b1010 -> port 1 is granted first.
